// File: rtl/capture_readout.sv
// Capture BRAM ring readout: streams 0x55, 0xAA, then every sample oldest-first, LS byte first.
// Optional trailing XOR checksum byte when READOUT_CHECKSUM_EN is defined.
`timescale 1ns/1ps

module capture_readout #(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDR_WIDTH          = 11,
  parameter int PRE_TRIGGER_SAMPLES = (1 << ADDR_WIDTH) / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  capture_done,
  input  logic [ADDR_WIDTH-1:0] trigger_index,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  readout_done
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS   = ADDR_WIDTH'(PRE_TRIGGER_SAMPLES);
  localparam logic [BYTE_W-1:0]     LAST_BYTE = BYTE_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_FIN
`ifdef READOUT_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                  state_q,      state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q,    rd_addr_d;
  logic [CNT_W-1:0]        sample_cnt_q, sample_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
  logic [BYTE_W-1:0]       byte_cnt_q,   byte_cnt_d;
  logic                    busy_q,       busy_d;
  logic [CNT_W-1:0]        cnt_inc;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]              csum_q,       csum_d;
`endif

  assign cnt_inc = sample_cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    sample_cnt_d = sample_cnt_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    busy_d       = busy_q;
`ifdef READOUT_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    rd_en        = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    readout_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && capture_done) begin
          state_d      = S_HDR0;
          busy_d       = 1'b1;
          rd_addr_d    = trigger_index - PRE_OFS;
          sample_cnt_d = '0;
          byte_cnt_d   = '0;
`ifdef READOUT_CHECKSUM_EN
          csum_d       = 8'h00;
`endif
        end
      end
      S_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        if (tx_ready) state_d = S_HDR1;
      end
      S_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        if (tx_ready) state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        shift_d    = rd_data;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[7:0];
        if (tx_ready) begin
`ifdef READOUT_CHECKSUM_EN
          csum_d = csum_q ^ shift_q[7:0];
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
            sample_cnt_d = cnt_inc;
            if (cnt_inc == DEPTH_CNT) begin
`ifdef READOUT_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_FIN;
`endif
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            shift_d    = shift_q >> 8;
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          end
        end
      end
`ifdef READOUT_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = S_FIN;
      end
`endif
      S_FIN: begin
        readout_done = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Losing capture_done mid-frame means the ring contents are no longer trustworthy.
    if (state_q != S_IDLE && state_q != S_FIN && !capture_done) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      sample_cnt_q <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      busy_q       <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      sample_cnt_q <= sample_cnt_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      busy_q       <= busy_d;
`ifdef READOUT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule
